// File: rtl/plaintext_tx_serializer.sv
// rtl/plaintext_tx_serializer.sv - double-buffered 128-bit plaintext block to byte-stream serializer
// Optional trailing XOR checksum byte per block: define PT_TX_CHECKSUM_EN.
module plaintext_tx_serializer #(
  parameter int BLOCK_BYTES = 16,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [8*BLOCK_BYTES-1:0] plaintext,
  input  logic                     plaintext_valid,
  output logic                     plaintext_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic [15:0]              blocks_sent,
  output logic                     overflow
);

  localparam int W  = 8 * BLOCK_BYTES;
  localparam int IW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_BYTES - 1);
  localparam logic [15:0]   GAP_LAST = 16'(GAP_CYCLES - 1);

`ifdef PT_TX_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_CSUM = 2'd2, ST_GAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_GAP = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic [W-1:0]    active_q, active_d;
  logic [W-1:0]    pend_q, pend_d;
  logic            pend_full_q, pend_full_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     gap_q, gap_d;
  logic [15:0]     blocks_q, blocks_d;
  logic            overflow_q, overflow_d;
`ifdef PT_TX_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic accept, tx_hs, eob, gap_done, blk_end, direct, load;

  assign plaintext_ready = !pend_full_q;
  assign accept          = plaintext_valid && !pend_full_q;
  assign tx_hs           = tx_valid && tx_ready;
  assign busy            = (state_q != ST_IDLE) || pend_full_q;
  assign blocks_sent     = blocks_q;
  assign overflow        = overflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
      gap_q       <= '0;
      blocks_q    <= '0;
      overflow_q  <= 1'b0;
`ifdef PT_TX_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      blocks_q    <= blocks_d;
      overflow_q  <= overflow_d;
`ifdef PT_TX_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    blocks_d    = blocks_q;
    overflow_d  = overflow_q | (plaintext_valid & pend_full_q);
`ifdef PT_TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    eob         = 1'b0;
    gap_done    = 1'b0;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: ;
      ST_SEND: begin
        if (tx_hs) begin
          active_d = active_q << 8;
          idx_d    = idx_q + 1'b1;
`ifdef PT_TX_CHECKSUM_EN
          csum_d   = csum_q ^ tx_data;
          if (idx_q == LAST_IDX) state_d = ST_CSUM;
`else
          eob      = (idx_q == LAST_IDX);
`endif
        end
      end
`ifdef PT_TX_CHECKSUM_EN
      ST_CSUM: eob = tx_hs;
`endif
      ST_GAP: begin
        if (gap_q == GAP_LAST) gap_done = 1'b1;
        else                   gap_d    = gap_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A block boundary with no gap behaves like IDLE for direct loads, so back-to-back has no bubble.
    blk_end = (eob && (GAP_CYCLES == 0)) || gap_done;
    direct  = accept && ((state_q == ST_IDLE) || blk_end);

    if (eob) blocks_d = blocks_q + 16'd1;

    if (eob && (GAP_CYCLES > 0)) begin
      state_d = ST_GAP;
      gap_d   = '0;
    end else if (blk_end && pend_full_q) begin
      active_d    = pend_q;
      pend_full_d = 1'b0;
      load        = 1'b1;
    end else if (direct) begin
      active_d = plaintext;
      load     = 1'b1;
    end else if (blk_end) begin
      state_d = ST_IDLE;
    end

    if (load) begin
      state_d = ST_SEND;
      idx_d   = '0;
`ifdef PT_TX_CHECKSUM_EN
      csum_d  = 8'h00;
`endif
    end

    if (accept && !direct) begin
      pend_d      = plaintext;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = active_q[W-1 -: 8];
      end
`ifdef PT_TX_CHECKSUM_EN
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_plaintext_tx_serializer.sv
// tb/tb_plaintext_tx_serializer.sv - scoreboard bench for plaintext_tx_serializer
module tb_plaintext_tx_serializer;

`ifdef PT_TX_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int BB    = 16;
  localparam int BYTES = BB + (CSUM ? 1 : 0);

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] plaintext;
  logic         plaintext_valid;
  logic         plaintext_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic [15:0]  blocks_sent;
  logic         overflow;

  always #5 clk = ~clk;

  plaintext_tx_serializer #(.BLOCK_BYTES(BB), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .plaintext(plaintext), .plaintext_valid(plaintext_valid),
    .plaintext_ready(plaintext_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .blocks_sent(blocks_sent), .overflow(overflow)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     tests = 0;
  int     fails = 0;
  int     exp_blocks = 0;
  bit     exp_ovf = 1'b0;
  int     hs_count = 0;
  bit     rdy_rand = 1'b0;
  bit     stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic [127:0] test_blk = 128'hABCDEF01020304050607080900000000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a block becomes its bytes MSB-first, plus XOR of all of them when enabled.
  task automatic push_block(input logic [127:0] blk);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < BB; i++) begin
      b = blk[127 - 8*i -: 8];
      x = x ^ b;
      exp_q.push_back('{b: b, last: (i == BB - 1) && !CSUM});
    end
    if (CSUM) exp_q.push_back('{b: x, last: 1'b1});
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (plaintext_valid && plaintext_ready) push_block(plaintext);
      else if (plaintext_valid) exp_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("tx_valid_vs_model", tx_valid, exp_q.size() != 0);
      chk("busy_vs_model", busy, exp_q.size() != 0);
      chk("blocks_sent_vs_model", blocks_sent, exp_blocks[15:0]);
      chk("overflow_vs_model", overflow, exp_ovf);
      if (stall_prev) chk("stall_hold", {tx_valid, tx_data}, {1'b1, stall_data});
      if (tx_valid && tx_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (tx_data !== mon_e.b) begin
            fails++;
            $display("FAIL tx_data: got %0h expected %0h", tx_data, mon_e.b);
          end
          hs_count++;
          if (mon_e.last) exp_blocks++;
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_data = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) tx_ready = ($urandom_range(0, 9) < 7);
  end

  // Caller sits at posedge+1; returns at posedge+1 just after the offering edge.
  task automatic offer(input logic [127:0] blk);
    plaintext       = blk;
    plaintext_valid = 1'b1;
    @(posedge clk); #1;
    plaintext_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: got %0d bytes outstanding expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_count < target && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL wait_hs_timeout: got %0d handshakes expected %0d", hs_count, target);
    end
  endtask

  initial begin
    int base;
    rst             = 1'b1;
    plaintext       = '0;
    plaintext_valid = 1'b0;
    tx_ready        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_valid", tx_valid, 1'b0);
    chk("reset_tx_data", tx_data, 8'h00);
    chk("reset_ready", plaintext_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_blocks", blocks_sent, 16'd0);
    chk("reset_overflow", overflow, 1'b0);
    rst = 1'b0;

    // single block, latency of first byte
    @(posedge clk); #1;
    offer(test_blk);
    chk("latency_valid", tx_valid, 1'b1);
    chk("latency_byte0", tx_data, 8'hAB);
    wait_idle();
    chk("single_blocks", blocks_sent, 16'd1);
    chk("single_busy", busy, 1'b0);

    // stall with byte 3 presented
    base = hs_count;
    offer(test_blk);
    wait_hs(base + 3);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", tx_valid, 1'b1);
      chk("stall_byte3", tx_data, 8'h01);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle();
    chk("stall_count", hs_count - base, BYTES);
    chk("stall_blocks", blocks_sent, 16'd2);

    // second block into pending while first is sending
    base = hs_count;
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    chk("pending_ready_low", plaintext_ready, 1'b0);
    wait_idle();
    chk("b2b_count", hs_count - base, 2 * BYTES);
    chk("b2b_blocks", blocks_sent, 16'd4);

    // three consecutive offers, third dropped
    base = hs_count;
    plaintext_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    plaintext_valid = 1'b0;
    wait_idle();
    chk("ovf_sticky", overflow, 1'b1);
    chk("ovf_count", hs_count - base, 2 * BYTES);
    chk("ovf_blocks", blocks_sent, 16'd6);

    // reset after the 7th byte handshake
    base = hs_count;
    offer(test_blk);
    wait_hs(base + 7);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    exp_blocks = 0;
    exp_ovf    = 1'b0;
    #1;
    chk("midrst_tx_valid", tx_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("postrst_ready", plaintext_ready, 1'b1);
    chk("postrst_busy", busy, 1'b0);
    chk("postrst_blocks", blocks_sent, 16'd0);
    chk("postrst_overflow", overflow, 1'b0);
    base = hs_count;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_no_bytes", hs_count - base, 0);

    // randomized traffic and backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      plaintext_valid = ($urandom_range(0, 3) == 0);
      plaintext       = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    plaintext_valid = 1'b0;
    wait_idle();
    rdy_rand = 1'b0;
    tx_ready = 1'b1;
    chk("random_final_blocks", blocks_sent, exp_blocks[15:0]);
    chk("random_final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/plaintext_tx_serializer.md
# plaintext_tx_serializer

Transmit-side counterpart to the hybrid RSA/AES receive path. It accepts a decrypted 128-bit plaintext block and serializes it MSB-first into a byte stream with a valid/ready handshake, ready for a UART transmitter. It sits between the decrypt core's `plaintext`/`plaintext_valid` outputs and the UART TX, and double-buffers so the next block can arrive while the current one is still being sent.

## Interface
- `BLOCK_BYTES`, 16: bytes per block; block width is 8*BLOCK_BYTES.
- `GAP_CYCLES`, 0: idle cycles with `tx_valid` low inserted after each block; 0 means back-to-back.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `plaintext`  in  8*BLOCK_BYTES  block to send; byte 0 is bits [MSB -: 8].
- `plaintext_valid`  in  1  block present; transfer occurs when valid && ready.
- `plaintext_ready`  out  1  pending buffer empty; block can be accepted.
- `tx_data`  out  8  current byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  UART TX accepts the byte; transfer occurs when tx_valid && tx_ready.
- `busy`  out  1  high whenever state != IDLE or the pending buffer is full.
- `blocks_sent`  out  16  count of fully transmitted blocks; wraps 0xFFFF->0.
- `overflow`  out  1  sticky: a block was offered while not ready and was dropped.

## Operation
- Storage: active shift register (current block), pending register plus `pend_full` flag, byte index counter (0..BLOCK_BYTES-1), gap counter.
- `plaintext_ready` = !pend_full (combinational from the flag).
- Accept rule: if the state is IDLE, or a final-byte handshake happens in the same cycle with GAP_CYCLES=0, and pend_full=0, the block loads directly into active. Otherwise it loads into pending.
- FSM states:
  - IDLE: tx_valid=0. On accept, go to SEND with index 0.
  - SEND: tx_valid=1, tx_data = active byte[index]. On handshake, the index increments. On the handshake of the last byte, go to CSUM if enabled, else end-of-block.
  - CSUM: tx_valid=1, tx_data = running XOR. On handshake, go to end-of-block.
  - GAP: tx_valid=0, count GAP_CYCLES, then move pending to active (go to SEND) or go to IDLE.
- End-of-block:
  - `blocks_sent` +1.
  - If GAP_CYCLES>0, go to GAP.
  - Else if pend_full, move pending to active, clear pend_full, and stay in SEND with index 0.
  - Else go to IDLE (or SEND, if a block is accepted directly that cycle).
- Overflow: plaintext_valid && !plaintext_ready sets `overflow`; the block is discarded and the buffers are unchanged. Only reset clears it.
- `tx_data` must hold stable while tx_valid && !tx_ready.
- Reset, including mid-block, clears everything: active and pending contents are lost and no partial byte is completed.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, plaintext_ready=1, busy=0, blocks_sent=0, overflow=0, state IDLE.
- Latency: block accepted at edge N gives byte 0 valid after edge N (cycle N+1).
- Throughput with tx_ready held high: one byte per clock. BLOCK_BYTES cycles per block (+1 with checksum), plus GAP_CYCLES.
- Back-to-back with GAP_CYCLES=0: the first byte of the next block follows the last byte (or checksum) on the next cycle with no bubble.
- A pending load and the transfer of pending to active never occur in the same cycle, because ready=0 while pend_full.

## Configuration
- `PT_TX_CHECKSUM_EN` defined: after the last data byte, one extra byte equal to the XOR of all block bytes is sent (CSUM state). `blocks_sent` increments on the checksum handshake.
- Not defined: the CSUM state and XOR register are absent, and exactly BLOCK_BYTES bytes are sent per block.

## Test plan
- Single block `ABCDEF01020304050607080900000000`, tx_ready=1 -> bytes AB,CD,EF,01,02,...,09,00,00,00,00 on 16 consecutive cycles starting the cycle after accept; blocks_sent=1; busy falls after the last byte.
- Same block, tx_ready low for 5 cycles while byte 3 is presented -> tx_data holds 0x01 with tx_valid=1 for all 5 cycles; no byte is skipped or duplicated.
- Two blocks offered back-to-back while sending (GAP_CYCLES=0) -> the second is accepted into pending and ready drops; its first byte follows the first block's last byte with no gap; blocks_sent=2.
- Three blocks offered on consecutive cycles, ignoring ready -> the third is dropped; overflow=1; exactly 32 bytes are sent.
- Reset asserted after the 7th byte handshake -> tx_valid=0 immediately; after release the block is idle, ready=1, blocks_sent=0, and no further bytes are sent.
- With `PT_TX_CHECKSUM_EN`, the same block -> a 17th byte of 0x88 is sent, then blocks_sent=1.
